// File: rtl/dram_port_arbiter_if.sv
// Bundle of the CPU, external-requester and DRAM signals around the data-DRAM port arbiter.
// slave modport: arbiter view (requests and dram_rdata in; grants, stall, read data and DRAM controls out).
// master modport: surrounding-system view (CPU, external requester and DRAM model), directions mirrored.
interface dram_port_arbiter_if;
    // CPU MEM-stage side
    logic        cpu_req;
    logic        cpu_wen;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    // External requester side (program loader / debug port)
    logic        ext_req;
    logic        ext_wen;
    logic [31:0] ext_addr;
    logic [31:0] ext_wdata;
    logic        ext_gnt;
    logic [31:0] ext_rdata;
    logic        ext_rvalid;
    // DRAM macro side
    logic [31:0] dram_addr;
    logic        dram_wen;
    logic [31:0] dram_wdata;
    logic [31:0] dram_rdata;

    modport slave (
        input  cpu_req, cpu_wen, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  ext_req, ext_wen, ext_addr, ext_wdata,
        output ext_gnt, ext_rdata, ext_rvalid,
        output dram_addr, dram_wen, dram_wdata,
        input  dram_rdata
    );

    modport master (
        output cpu_req, cpu_wen, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output ext_req, ext_wen, ext_addr, ext_wdata,
        input  ext_gnt, ext_rdata, ext_rvalid,
        input  dram_addr, dram_wen, dram_wdata,
        output dram_rdata
    );
endinterface

// File: rtl/dram_port_arbiter.sv
// Shares the single data-DRAM port between the CPU MEM stage and an external requester.
// Latency: writes complete in the grant cycle; reads return RD_LAT cycles after grant
// (CPU data combinationally in the completion cycle, external data registered one cycle later).
// Backpressure: cpu_stall holds the CPU until its access completes; ext_gnt is a one-cycle accept.
// Ports: clk, rst (synchronous, active-high), bus (dram_port_arbiter_if.slave).
module dram_port_arbiter #(
    parameter int RD_LAT     = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               rst,
    dram_port_arbiter_if.slave bus
);
    localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    typedef enum logic { IDLE, READ } state_t;
    typedef enum logic { OWN_CPU, OWN_EXT } owner_t;

    state_t         state_q, state_d;
    owner_t         owner_q, owner_d;
    logic [31:0]    addr_q, addr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [SW-1:0]  starve_q, starve_d;
    logic [31:0]    ext_rdata_q, ext_rdata_d;
    logic           ext_rvalid_q, ext_rvalid_d;

    logic           cpu_win, ext_win, cpu_done, starve_hit;
    logic           win_wen;
    logic [31:0]    win_addr, win_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= OWN_CPU;
            addr_q       <= '0;
            cnt_q        <= '0;
            starve_q     <= '0;
            ext_rdata_q  <= '0;
            ext_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            starve_q     <= starve_d;
            ext_rdata_q  <= ext_rdata_d;
            ext_rvalid_q <= ext_rvalid_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        addr_d         = addr_q;
        cnt_d          = cnt_q;
        starve_d       = starve_q;
        ext_rdata_d    = ext_rdata_q;
        ext_rvalid_d   = 1'b0;
        cpu_win        = 1'b0;
        ext_win        = 1'b0;
        cpu_done       = 1'b0;
        win_wen        = 1'b0;
        win_addr       = '0;
        win_wdata      = '0;
        starve_hit     = (starve_q == SW'(STARVE_MAX));
        bus.dram_addr  = '0;
        bus.dram_wen   = 1'b0;
        bus.dram_wdata = '0;
        bus.ext_gnt    = 1'b0;
        bus.cpu_stall  = 1'b0;
        bus.cpu_rdata  = '0;

        // While rst is high every combinational output stays at its default and
        // nothing below runs, which is also what aborts an in-flight read.
        if (!rst) begin
            if (state_q == IDLE) begin
                // CPU has fixed priority unless the external side has been passed over
                // STARVE_MAX times in a row.
                ext_win = bus.ext_req && (!bus.cpu_req || starve_hit);
                cpu_win = bus.cpu_req && !ext_win;

                if (cpu_win) begin
                    win_wen   = bus.cpu_wen;
                    win_addr  = bus.cpu_addr;
                    win_wdata = bus.cpu_wdata;
                    cpu_done  = bus.cpu_wen;
                end else if (ext_win) begin
                    win_wen     = bus.ext_wen;
                    win_addr    = bus.ext_addr;
                    win_wdata   = bus.ext_wdata;
                    bus.ext_gnt = 1'b1;
                end

                bus.dram_addr  = win_addr;
                bus.dram_wen   = win_wen;
                bus.dram_wdata = win_wen ? win_wdata : '0;

                // Writes finish in the grant cycle and stay in IDLE; reads hold the
                // port and keep the address stable for the DRAM latency.
                if ((cpu_win || ext_win) && !win_wen) begin
                    state_d = READ;
                    owner_d = cpu_win ? OWN_CPU : OWN_EXT;
                    addr_d  = win_addr;
                    cnt_d   = CW'(RD_LAT - 1);
                end
            end else begin
                bus.dram_addr = addr_q;
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    if (owner_q == OWN_CPU) begin
                        bus.cpu_rdata = bus.dram_rdata;
                        cpu_done      = 1'b1;
                    end else begin
                        ext_rdata_d  = bus.dram_rdata;
                        ext_rvalid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            if (!bus.ext_req || ext_win) begin
                starve_d = '0;
            end else if (cpu_win && !starve_hit) begin
                starve_d = starve_q + 1'b1;
            end

            bus.cpu_stall = bus.cpu_req && !cpu_done;
        end
    end

    assign bus.ext_rdata  = ext_rdata_q;
    assign bus.ext_rvalid = ext_rvalid_q;
endmodule

// File: tb/tb_dram_port_arbiter.sv
// Self-checking bench for dram_port_arbiter: directed scenarios plus a randomized run
// checked against a cycle-number based reference model of the arbitration rules.
// Inputs change 1ns after the rising edge; outputs are sampled 2ns after it.
module tb_dram_port_arbiter;
    localparam int RD_LAT = 2;
    localparam int SMAX   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nvec = 0;
    int   nerr = 0;

    dram_port_arbiter_if bus ();

    dram_port_arbiter #(.RD_LAT(RD_LAT), .STARVE_MAX(SMAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_cpu(input logic req, input logic wen, input logic [31:0] a, input logic [31:0] d);
        bus.cpu_req   = req;
        bus.cpu_wen   = wen;
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
    endtask

    task automatic drive_ext(input logic req, input logic wen, input logic [31:0] a, input logic [31:0] d);
        bus.ext_req   = req;
        bus.ext_wen   = wen;
        bus.ext_addr  = a;
        bus.ext_wdata = d;
    endtask

    task automatic go_idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            rst = 1'b0;
            drive_cpu(1'b0, 1'b0, 32'h0, 32'h0);
            drive_ext(1'b0, 1'b0, 32'h0, 32'h0);
            bus.dram_rdata = 32'hA5A5_0000;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            tick();
            rst = 1'b1;
            drive_cpu(1'b1, 1'b1, 32'h44, 32'h1111_2222);
            drive_ext(1'b1, 1'b1, 32'h88, 32'h3333_4444);
            settle();
            nvec++; if (bus.dram_wen !== 1'b0) begin nerr++; $display("FAIL rst_wen: got %0h want 0", bus.dram_wen); end
            nvec++; if (bus.ext_gnt !== 1'b0) begin nerr++; $display("FAIL rst_gnt: got %0h want 0", bus.ext_gnt); end
            nvec++; if (bus.cpu_stall !== 1'b0) begin nerr++; $display("FAIL rst_stall: got %0h want 0", bus.cpu_stall); end
            nvec++; if (bus.dram_addr !== 32'h0) begin nerr++; $display("FAIL rst_addr: got %h want 0", bus.dram_addr); end
            nvec++; if (bus.dram_wdata !== 32'h0) begin nerr++; $display("FAIL rst_wdata: got %h want 0", bus.dram_wdata); end
        end
        go_idle(1);
        settle();
        nvec++; if (bus.ext_rvalid !== 1'b0) begin nerr++; $display("FAIL rst_rvalid: got %0h want 0", bus.ext_rvalid); end
        nvec++; if (bus.ext_rdata !== 32'h0) begin nerr++; $display("FAIL rst_rdata: got %h want 0", bus.ext_rdata); end
        nvec++; if (bus.cpu_rdata !== 32'h0) begin nerr++; $display("FAIL idle_cpu_rdata: got %h want 0", bus.cpu_rdata); end
        nvec++; if (bus.dram_addr !== 32'h0) begin nerr++; $display("FAIL idle_addr: got %h want 0", bus.dram_addr); end
    endtask

    task automatic test_cpu_store();
        tick();
        drive_cpu(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
        settle();
        nvec++; if (bus.dram_wen !== 1'b1) begin nerr++; $display("FAIL store_wen: got %0h want 1", bus.dram_wen); end
        nvec++; if (bus.dram_addr !== 32'h10) begin nerr++; $display("FAIL store_addr: got %h want 10", bus.dram_addr); end
        nvec++; if (bus.dram_wdata !== 32'hDEAD_BEEF) begin nerr++; $display("FAIL store_wdata: got %h want deadbeef", bus.dram_wdata); end
        nvec++; if (bus.cpu_stall !== 1'b0) begin nerr++; $display("FAIL store_stall: got %0h want 0", bus.cpu_stall); end
        go_idle(1);
    endtask

    task automatic test_cpu_load();
        for (int i = 0; i <= RD_LAT; i++) begin
            tick();
            drive_cpu(1'b1, 1'b0, 32'h20, 32'h0);
            bus.dram_rdata = (i == RD_LAT) ? 32'h1234_5678 : 32'h7777_7777;
            settle();
            nvec++; if (bus.dram_addr !== 32'h20) begin nerr++; $display("FAIL load_addr[%0d]: got %h want 20", i, bus.dram_addr); end
            nvec++; if (bus.dram_wen !== 1'b0) begin nerr++; $display("FAIL load_wen[%0d]: got %0h want 0", i, bus.dram_wen); end
            nvec++; if (bus.cpu_stall !== (i < RD_LAT)) begin nerr++; $display("FAIL load_stall[%0d]: got %0h want %0h", i, bus.cpu_stall, (i < RD_LAT)); end
            if (i == RD_LAT) begin
                nvec++; if (bus.cpu_rdata !== 32'h1234_5678) begin nerr++; $display("FAIL load_rdata: got %h want 12345678", bus.cpu_rdata); end
            end
        end
        go_idle(1);
        settle();
        nvec++; if (bus.cpu_rdata !== 32'h0) begin nerr++; $display("FAIL load_rdata_after: got %h want 0", bus.cpu_rdata); end
    endtask

    task automatic test_ext_read();
        for (int i = 0; i <= RD_LAT + 2; i++) begin
            tick();
            drive_ext(i == 0, 1'b0, 32'h40, 32'h0);
            bus.dram_rdata = (i == RD_LAT) ? 32'hCAFE_F00D : 32'h0BAD_0BAD;
            settle();
            nvec++; if (bus.ext_gnt !== (i == 0)) begin nerr++; $display("FAIL extrd_gnt[%0d]: got %0h want %0h", i, bus.ext_gnt, (i == 0)); end
            nvec++; if (bus.ext_rvalid !== (i == RD_LAT + 1)) begin nerr++; $display("FAIL extrd_rvalid[%0d]: got %0h want %0h", i, bus.ext_rvalid, (i == RD_LAT + 1)); end
            if (i <= RD_LAT) begin
                nvec++; if (bus.dram_addr !== 32'h40) begin nerr++; $display("FAIL extrd_addr[%0d]: got %h want 40", i, bus.dram_addr); end
            end else begin
                nvec++; if (bus.ext_rdata !== 32'hCAFE_F00D) begin nerr++; $display("FAIL extrd_rdata[%0d]: got %h want cafef00d", i, bus.ext_rdata); end
            end
        end
        go_idle(1);
    endtask

    task automatic test_contention();
        for (int i = 0; i <= SMAX + 1; i++) begin
            int k;
            k = (i > SMAX) ? SMAX : i;
            tick();
            drive_cpu(1'b1, 1'b1, 32'h100 + k, 32'h5000_0000 + k);
            drive_ext(i <= SMAX, 1'b1, 32'h200, 32'hE0E0_E0E0);
            settle();
            if (i == SMAX) begin
                nvec++; if (bus.ext_gnt !== 1'b1) begin nerr++; $display("FAIL cont_gnt[%0d]: got %0h want 1", i, bus.ext_gnt); end
                nvec++; if (bus.dram_wdata !== 32'hE0E0_E0E0) begin nerr++; $display("FAIL cont_wdata[%0d]: got %h want e0e0e0e0", i, bus.dram_wdata); end
                nvec++; if (bus.dram_addr !== 32'h200) begin nerr++; $display("FAIL cont_addr[%0d]: got %h want 200", i, bus.dram_addr); end
                nvec++; if (bus.cpu_stall !== 1'b1) begin nerr++; $display("FAIL cont_stall[%0d]: got %0h want 1", i, bus.cpu_stall); end
            end else begin
                nvec++; if (bus.ext_gnt !== 1'b0) begin nerr++; $display("FAIL cont_gnt[%0d]: got %0h want 0", i, bus.ext_gnt); end
                nvec++; if (bus.dram_wdata !== 32'h5000_0000 + k) begin nerr++; $display("FAIL cont_wdata[%0d]: got %h want %h", i, bus.dram_wdata, 32'h5000_0000 + k); end
                nvec++; if (bus.cpu_stall !== 1'b0) begin nerr++; $display("FAIL cont_stall[%0d]: got %0h want 0", i, bus.cpu_stall); end
            end
            nvec++; if (bus.dram_wen !== 1'b1) begin nerr++; $display("FAIL cont_wen[%0d]: got %0h want 1", i, bus.dram_wen); end
        end
        go_idle(1);
    endtask

    task automatic test_ext_then_cpu();
        logic [31:0] ea [6];
        logic [5:0]  st;
        ea = '{32'h80, 32'h80, 32'h80, 32'h90, 32'h90, 32'h90};
        st = 6'b011110;
        for (int i = 0; i < 6; i++) begin
            tick();
            drive_ext(i == 0, 1'b0, 32'h80, 32'h0);
            drive_cpu(i >= 1, 1'b0, 32'h90, 32'h0);
            bus.dram_rdata = (i == 2) ? 32'h55AA_55AA : ((i == 5) ? 32'h0BAD_F00D : 32'h1357_9BDF);
            settle();
            nvec++; if (bus.dram_addr !== ea[i]) begin nerr++; $display("FAIL xc_addr[%0d]: got %h want %h", i, bus.dram_addr, ea[i]); end
            nvec++; if (bus.cpu_stall !== st[i]) begin nerr++; $display("FAIL xc_stall[%0d]: got %0h want %0h", i, bus.cpu_stall, st[i]); end
            nvec++; if (bus.ext_rvalid !== (i == 3)) begin nerr++; $display("FAIL xc_rvalid[%0d]: got %0h want %0h", i, bus.ext_rvalid, (i == 3)); end
            if (i == 3) begin
                nvec++; if (bus.ext_rdata !== 32'h55AA_55AA) begin nerr++; $display("FAIL xc_rdata: got %h want 55aa55aa", bus.ext_rdata); end
            end
            if (i == 5) begin
                nvec++; if (bus.cpu_rdata !== 32'h0BAD_F00D) begin nerr++; $display("FAIL xc_cpu_rdata: got %h want 0badf00d", bus.cpu_rdata); end
            end
        end
        go_idle(1);
    endtask

    task automatic test_reset_mid_read();
        // CPU load aborted by reset one cycle after its grant
        tick();
        drive_cpu(1'b1, 1'b0, 32'h30, 32'h0);
        settle();
        nvec++; if (bus.cpu_stall !== 1'b1) begin nerr++; $display("FAIL rmr_stall0: got %0h want 1", bus.cpu_stall); end
        tick();
        rst = 1'b1;
        settle();
        nvec++; if (bus.cpu_stall !== 1'b0) begin nerr++; $display("FAIL rmr_stall_rst: got %0h want 0", bus.cpu_stall); end
        nvec++; if (bus.dram_wen !== 1'b0) begin nerr++; $display("FAIL rmr_wen_rst: got %0h want 0", bus.dram_wen); end
        nvec++; if (bus.dram_addr !== 32'h0) begin nerr++; $display("FAIL rmr_addr_rst: got %h want 0", bus.dram_addr); end
        go_idle(1);
        settle();
        nvec++; if (bus.dram_addr !== 32'h0) begin nerr++; $display("FAIL rmr_addr_idle: got %h want 0", bus.dram_addr); end
        nvec++; if (bus.cpu_rdata !== 32'h0) begin nerr++; $display("FAIL rmr_cpu_rdata: got %h want 0", bus.cpu_rdata); end
        // External read aborted by reset; a CPU store right after must be granted at once
        tick();
        drive_ext(1'b1, 1'b0, 32'h60, 32'h0);
        settle();
        nvec++; if (bus.ext_gnt !== 1'b1) begin nerr++; $display("FAIL rmr_xgnt: got %0h want 1", bus.ext_gnt); end
        tick();
        rst = 1'b1;
        drive_ext(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        rst = 1'b0;
        drive_cpu(1'b1, 1'b1, 32'h34, 32'h0000_0034);
        settle();
        nvec++; if (bus.dram_wen !== 1'b1) begin nerr++; $display("FAIL rmr_post_wen: got %0h want 1", bus.dram_wen); end
        nvec++; if (bus.dram_addr !== 32'h34) begin nerr++; $display("FAIL rmr_post_addr: got %h want 34", bus.dram_addr); end
        nvec++; if (bus.cpu_stall !== 1'b0) begin nerr++; $display("FAIL rmr_post_stall: got %0h want 0", bus.cpu_stall); end
        nvec++; if (bus.ext_rvalid !== 1'b0) begin nerr++; $display("FAIL rmr_rvalid0: got %0h want 0", bus.ext_rvalid); end
        go_idle(1);
        settle();
        nvec++; if (bus.ext_rvalid !== 1'b0) begin nerr++; $display("FAIL rmr_rvalid1: got %0h want 0", bus.ext_rvalid); end
        go_idle(1);
    endtask

    // Reference model: time is tracked in cycle numbers. A read granted in cycle c
    // occupies the port through cycle c+RD_LAT; external data shows up the cycle after.
    task automatic test_random();
        int          busy_until, rv_cycle, starve, owner;
        logic [31:0] rd_addr, xrd_exp;
        logic        prev_stall, prev_xpend;
        busy_until = -1; rv_cycle = -1; starve = 0; owner = 0;
        rd_addr = 0; xrd_exp = 0; prev_stall = 0; prev_xpend = 0;
        for (int c = 0; c < 800; c++) begin
            logic        r, idle, cw, xw, wwen, comp, done, e_stall;
            logic [31:0] e_addr, e_wdata, e_cpur, drd;
            tick();
            r = (c == 0) || ($urandom_range(0, 79) == 0);
            rst = r;
            if (!prev_stall)
                drive_cpu($urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1, $urandom & 32'hFFFC, $urandom);
            if (!prev_xpend)
                drive_ext($urandom_range(0, 9) < 4, $urandom_range(0, 1) == 1, $urandom & 32'hFFFC, $urandom);
            drd = $urandom;
            bus.dram_rdata = drd;
            settle();

            idle = (c > busy_until);
            cw = 1'b0; xw = 1'b0;
            if (!r && idle) begin
                if (bus.cpu_req && bus.ext_req) begin
                    xw = (starve == SMAX);
                    cw = !xw;
                end else begin
                    cw = bus.cpu_req;
                    xw = bus.ext_req;
                end
            end
            comp    = !r && !idle && (c == busy_until);
            wwen    = cw ? bus.cpu_wen : (xw ? bus.ext_wen : 1'b0);
            e_addr  = cw ? bus.cpu_addr : (xw ? bus.ext_addr : ((!r && !idle) ? rd_addr : 32'h0));
            e_wdata = cw ? bus.cpu_wdata : bus.ext_wdata;
            e_cpur  = (comp && owner == 0) ? drd : 32'h0;
            done    = (cw && bus.cpu_wen) || (comp && owner == 0);
            e_stall = !r && bus.cpu_req && !done;

            nvec++; if (bus.dram_wen !== wwen) begin nerr++; $display("FAIL rnd_wen c=%0d: got %0h want %0h", c, bus.dram_wen, wwen); end
            nvec++; if (bus.dram_addr !== e_addr) begin nerr++; $display("FAIL rnd_addr c=%0d: got %h want %h", c, bus.dram_addr, e_addr); end
            nvec++; if (bus.ext_gnt !== xw) begin nerr++; $display("FAIL rnd_gnt c=%0d: got %0h want %0h", c, bus.ext_gnt, xw); end
            nvec++; if (bus.cpu_stall !== e_stall) begin nerr++; $display("FAIL rnd_stall c=%0d: got %0h want %0h", c, bus.cpu_stall, e_stall); end
            nvec++; if (bus.cpu_rdata !== e_cpur) begin nerr++; $display("FAIL rnd_cpu_rdata c=%0d: got %h want %h", c, bus.cpu_rdata, e_cpur); end
            if (wwen) begin
                nvec++; if (bus.dram_wdata !== e_wdata) begin nerr++; $display("FAIL rnd_wdata c=%0d: got %h want %h", c, bus.dram_wdata, e_wdata); end
            end else if (r || (idle && !cw && !xw)) begin
                nvec++; if (bus.dram_wdata !== 32'h0) begin nerr++; $display("FAIL rnd_wdata0 c=%0d: got %h want 0", c, bus.dram_wdata); end
            end
            if (c > 0) begin
                nvec++; if (bus.ext_rvalid !== (c == rv_cycle)) begin nerr++; $display("FAIL rnd_rvalid c=%0d: got %0h want %0h", c, bus.ext_rvalid, (c == rv_cycle)); end
                nvec++; if (bus.ext_rdata !== xrd_exp) begin nerr++; $display("FAIL rnd_rdata c=%0d: got %h want %h", c, bus.ext_rdata, xrd_exp); end
            end

            if (r) begin
                busy_until = -1; rv_cycle = -1; starve = 0; xrd_exp = 32'h0;
            end else begin
                if (comp && owner == 1) begin
                    xrd_exp  = drd;
                    rv_cycle = c + 1;
                end
                if ((cw || xw) && !wwen) begin
                    busy_until = c + RD_LAT;
                    owner      = xw ? 1 : 0;
                    rd_addr    = e_addr;
                end
                if (!bus.ext_req || xw) starve = 0;
                else if (cw && starve < SMAX) starve = starve + 1;
            end
            prev_stall = e_stall;
            prev_xpend = bus.ext_req && !xw;
        end
        go_idle(1);
    endtask

    initial begin
        rst = 1'b1;
        drive_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        drive_ext(1'b0, 1'b0, 32'h0, 32'h0);
        bus.dram_rdata = 32'h0;
        test_reset();
        test_cpu_store();
        test_cpu_load();
        test_ext_read();
        test_contention();
        test_ext_then_cpu();
        test_reset_mid_read();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/dram_port_arbiter.md
Name: dram_port_arbiter

Overview:
- Shares the single data-DRAM port between the CPU MEM stage and an external requester (program loader / debug port).
- Sequences multi-cycle reads and freezes the CPU pipeline via cpu_stall while the port is busy or owned by the external side.
- Sits between the CPU data-memory outputs and the DRAM macro. Fixed CPU priority, with starvation escape for the external side.

Parameters:
- RD_LAT, 2, DRAM read latency in cycles (>=1); dram_addr must be held stable during this period.
- STARVE_MAX, 4, maximum consecutive CPU grants while ext_req is pending before ext is forced.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU MEM-stage load/store valid
- cpu_wen  in  1  1=store, 0=load
- cpu_addr  in  32  CPU byte address
- cpu_wdata  in  32  store data
- cpu_rdata  out  32  load data, valid in the CPU read completion cycle
- cpu_stall  out  1  freeze pipeline
- ext_req  in  1  external request; held with addr/data until ext_gnt
- ext_wen  in  1  1=write, 0=read
- ext_addr  in  32  external address
- ext_wdata  in  32  external write data
- ext_gnt  out  1  one-cycle accept pulse
- ext_rdata  out  32  registered read data, held until the next ext read completes
- ext_rvalid  out  1  one-cycle pulse when ext_rdata updates
- dram_addr  out  32  DRAM address
- dram_wen  out  1  DRAM write enable
- dram_wdata  out  32  DRAM write data
- dram_rdata  in  32  DRAM read data, valid RD_LAT cycles after the address is first driven

Behaviour:
- FSM states: IDLE, READ. Registers: state, owner (CPU/EXT), latched addr, cnt, starve_cnt, ext_rdata, ext_rvalid.
- Reset (rst=1 at clock edge):
  - state=IDLE, cnt=0, starve_cnt=0, ext_rdata=0, ext_rvalid=0.
  - While rst=1, all combinational outputs are forced: dram_wen=0, ext_gnt=0, cpu_stall=0, dram_addr=0, dram_wdata=0.
  - Reset mid-read aborts the read; no rvalid is produced and no stall follows.
- Arbitration (IDLE only, combinational in the same cycle):
  - Only one requester active: grant it.
  - Both active: grant CPU unless starve_cnt==STARVE_MAX, in which case grant EXT.
- starve_cnt updates:
  - +1 on each CPU grant while ext_req=1, saturating at STARVE_MAX.
  - Cleared on an EXT grant, or on any cycle with ext_req=0.
- Write grant at cycle t:
  - dram_wen=1, dram_addr/dram_wdata come from the winner, combinationally in cycle t.
  - State stays IDLE, so back-to-back writes are possible every cycle.
  - EXT winner: ext_gnt=1 in cycle t.
- Read grant at cycle t:
  - dram_addr comes from the winner in cycle t; addr is latched, owner is set, state goes to READ with cnt=RD_LAT-1.
  - In READ: dram_addr = latched addr, dram_wen=0, cnt decrements each cycle. cnt==0 marks the completion cycle t+RD_LAT; next state is IDLE.
  - No arbitration during READ. The earliest next grant is cycle t+RD_LAT+1.
  - EXT read: ext_gnt=1 at cycle t.
- Read completion, cycle t+RD_LAT:
  - CPU owner: cpu_rdata = dram_rdata (combinational passthrough).
  - EXT owner: ext_rdata <= dram_rdata, ext_rvalid=1 in cycle t+RD_LAT+1 only.
- Idle outputs: with no grant and no READ, dram_addr=0, dram_wdata=0, dram_wen=0. cpu_rdata=0 outside the CPU completion cycle.
- cpu_stall = cpu_req AND NOT cpu_done, where cpu_done means either:
  - CPU write granted this cycle, or
  - CPU-owned READ with cnt==0.
- Resulting stall lengths:
  - CPU write alone: 0 stall cycles.
  - CPU read: stall in cycles t..t+RD_LAT-1, released at t+RD_LAT.
  - cpu_req during an EXT access or EXT grant: stall until CPU is granted and completes.
- Requester rules:
  - EXT must drop or replace its request the cycle after ext_gnt; a still-asserted ext_req is treated as a new request.
  - The CPU holds its request stable while stalled.

Test Plan:
- CPU store alone: cpu_req=1, cpu_wen=1, addr=0x10, wdata=0xDEADBEEF -> same cycle dram_wen=1, dram_addr=0x10, dram_wdata=0xDEADBEEF, cpu_stall=0.
- CPU load (RD_LAT=2), addr=0x20, DRAM returns 0x12345678 -> cpu_stall=1 for 2 cycles with dram_addr=0x20 held; cycle 3 cpu_stall=0, cpu_rdata=0x12345678.
- EXT read alone, addr=0x40, DRAM returns 0xCAFEF00D -> ext_gnt pulse at t; ext_rvalid=1 at t+3 with ext_rdata=0xCAFEF00D, which is held afterwards.
- Contention: continuous CPU stores plus a pending EXT write (STARVE_MAX=4) -> CPU wins 4 cycles; 5th cycle ext_gnt=1, dram_wdata=ext_wdata, cpu_stall=1; starve_cnt returns to 0 and the CPU wins the 6th cycle.
- EXT read in flight, cpu_req load arrives at t+1 -> cpu_stall high through t+2; CPU granted t+3, completes at t+5 with stall=0.
- rst pulsed at t+1 of a CPU read -> next cycle state IDLE, dram_wen=0, cpu_stall=0 while rst=1; ext_rvalid never pulses.
